// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: control side of the EX-stage operand forwarding path of a
// 5-stage pipeline. Shadows destination-register info of the ID/EX, EX/MEM
// and MEM/WB stages and derives operand-mux selects, load-use stall and
// bubble insertion from that state.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), asynchronous active-low reset
//   id_valid_i               ID stage holds a real instruction
//   id_rs_i, id_rt_i         ID source registers
//   id_dst_i                 ID destination register (after RegDst select)
//   id_regwrite_i            ID instruction writes the register file
//   id_memread_i             ID instruction is a load
//   id_use_rt_i              ID instruction reads rt
//   flush_i                  discard the ID instruction (branch/jump taken)
//   fwd_a_sel_o, fwd_b_sel_o operand mux selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_o                  hold PC and IF/ID this cycle (load-use hazard)
//   idex_bubble_o            ID/EX slot holds a bubble
//   id_byp_a_o, id_byp_b_o   (FWD_ID_BYPASS_EN only) MEM/WB writes id_rs_i / id_rt_i
//
// Optional feature macro: FWD_ID_BYPASS_EN adds the ID-stage write-back bypass
// outputs for use with a read-before-write register file.

module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW             = 5,
    parameter int unsigned NUM_STAGES_TRACKED = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_use_rt_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
`ifdef FWD_ID_BYPASS_EN
    output logic              id_byp_a_o,
    output logic              id_byp_b_o,
`endif
    output logic              idex_bubble_o
);

    if (NUM_STAGES_TRACKED != 3) begin : g_bad_stages
        $error("fwd_hazard_ctrl supports exactly 3 tracked stages");
    end

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rt;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
    } stage_t;

    idex_t  idex_d, idex_q;
    stage_t exmem_d, exmem_q;
    stage_t memwb_d, memwb_q;
    logic   stall;

    // A stage supplies register r only if it really writes it; r0 is hardwired zero.
    function automatic logic stage_writes(stage_t s, logic [REG_AW-1:0] r);
        return s.valid & s.regwrite & (s.dst == r) & (r != '0);
    endfunction

    // Load in EX whose result the ID instruction needs: hold ID one cycle.
    // A flush kills the ID instruction, so it cannot cause a stall.
    always_comb begin
        stall = id_valid_i & ~flush_i & idex_q.valid & idex_q.memread &
                (idex_q.dst != '0) &
                ((idex_q.dst == id_rs_i) | (id_use_rt_i & (idex_q.dst == id_rt_i)));
    end

    always_comb begin
        idex_d.valid    = id_valid_i;
        idex_d.rs       = id_rs_i;
        idex_d.rt       = id_rt_i;
        idex_d.use_rt   = id_use_rt_i;
        idex_d.dst      = id_dst_i;
        idex_d.regwrite = id_regwrite_i;
        idex_d.memread  = id_memread_i;
        if (stall || flush_i) begin
            idex_d = '0;
        end
    end

    // Downstream of ID never freezes: stages always advance.
    always_comb begin
        exmem_d.valid    = idex_q.valid;
        exmem_d.dst      = idex_q.dst;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        memwb_d          = exmem_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // EX/MEM checked first: the newest producer wins on a double hit. A load in
    // EX/MEM never matches a consumer in EX thanks to the load-use stall.
    always_comb begin
        fwd_a_sel_o = 2'b00;
        if (stage_writes(exmem_q, idex_q.rs)) begin
            fwd_a_sel_o = 2'b10;
        end else if (stage_writes(memwb_q, idex_q.rs)) begin
            fwd_a_sel_o = 2'b01;
        end

        fwd_b_sel_o = 2'b00;
        if (idex_q.use_rt) begin
            if (stage_writes(exmem_q, idex_q.rt)) begin
                fwd_b_sel_o = 2'b10;
            end else if (stage_writes(memwb_q, idex_q.rt)) begin
                fwd_b_sel_o = 2'b01;
            end
        end
    end

    assign stall_o       = stall;
    assign idex_bubble_o = ~idex_q.valid;

`ifdef FWD_ID_BYPASS_EN
    assign id_byp_a_o = stage_writes(memwb_q, id_rs_i);
    assign id_byp_b_o = stage_writes(memwb_q, id_rt_i);
`endif

    // Load flag is carried into MEM/WB for completeness; nothing consumes it there.
    logic unused_memwb_memread;
    assign unused_memwb_memread = memwb_q.memread;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_regwrite, id_memread, id_use_rt, flush;
    logic [1:0] fwd_a, fwd_b;
    logic       stall, bubble;
`ifdef FWD_ID_BYPASS_EN
    logic       byp_a, byp_b;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .NUM_STAGES_TRACKED(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_dst_i      (id_dst),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .id_use_rt_i   (id_use_rt),
        .flush_i       (flush),
        .fwd_a_sel_o   (fwd_a),
        .fwd_b_sel_o   (fwd_b),
        .stall_o       (stall),
`ifdef FWD_ID_BYPASS_EN
        .id_byp_a_o    (byp_a),
        .id_byp_b_o    (byp_b),
`endif
        .idex_bubble_o (bubble)
    );

    // ---------------- behavioural model ----------------
    // History of what entered EX; index 0 is in EX, 1 in MEM, 2 in WB.
    typedef struct {
        bit       v;
        bit [4:0] rs, rt, dst;
        bit       use_rt, rw, mr;
    } ins_t;

    ins_t pipe[$];

    function automatic ins_t at(int k);
        ins_t z;
        z = '{default: 0};
        if (k < pipe.size()) return pipe[k];
        return z;
    endfunction

    function automatic bit writes(ins_t s, bit [4:0] r);
        return s.v && s.rw && s.dst == r && r != 0;
    endfunction

    function automatic int src_sel(bit [4:0] r);
        if (writes(at(1), r)) return 2;
        if (writes(at(2), r)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        ins_t ex;
        ex = at(0);
        if (!id_valid || flush) return 0;
        if (!(ex.v && ex.mr && ex.dst != 0)) return 0;
        return ex.dst == id_rs || (id_use_rt && ex.dst == id_rt);
    endfunction

    function automatic int exp_a();
        return src_sel(at(0).rs);
    endfunction

    function automatic int exp_b();
        if (!at(0).use_rt) return 0;
        return src_sel(at(0).rt);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
        end else begin
            ins_t n;
            n = '{default: 0};
            if (!(model_stall() || flush)) begin
                n.v = id_valid; n.rs = id_rs; n.rt = id_rt; n.dst = id_dst;
                n.use_rt = id_use_rt; n.rw = id_regwrite; n.mr = id_memread;
            end
            pipe.push_front(n);
            if (pipe.size() > 3) void'(pipe.pop_back());
        end
    end

    task automatic check(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model every cycle, away from the edge.
    always @(negedge clk) begin
        check("model_fwd_a", int'(fwd_a), exp_a());
        check("model_fwd_b", int'(fwd_b), exp_b());
        check("model_stall", int'(stall), int'(model_stall()));
        check("model_bubble", int'(bubble), int'(!at(0).v));
`ifdef FWD_ID_BYPASS_EN
        check("model_byp_a", int'(byp_a), int'(writes(at(2), id_rs)));
        check("model_byp_b", int'(byp_b), int'(writes(at(2), id_rt)));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] dst,
                         bit rw, bit mr, bit urt, bit fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_regwrite = rw; id_memread = mr; id_use_rt = urt; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // R-type: rd <- rs op rt
    task automatic rtype(bit [4:0] rd, bit [4:0] rs, bit [4:0] rt);
        drive(1, rs, rt, rd, 1, 0, 1, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectation, sampled mid-cycle.
    task automatic pin(string name, int ea, int eb, int es, int ebub);
        @(negedge clk);
        #1;
        check({name, "_a"}, int'(fwd_a), ea);
        check({name, "_b"}, int'(fwd_b), eb);
        check({name, "_stall"}, int'(stall), es);
        check({name, "_bubble"}, int'(bubble), ebub);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        idle();
        pin("reset", 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
        pin("post_reset", 0, 0, 0, 1);
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5
        rtype(3, 1, 2); tick();
        rtype(4, 3, 5); tick();
        idle();
        pin("b2b", 2, 0, 0, 0);
        drain();

        // add $3 ; nop ; or $6,$3,$3
        rtype(3, 1, 2); tick();
        idle(); tick();
        rtype(6, 3, 3); tick();
        idle();
        pin("dist2", 1, 1, 0, 0);
        drain();

        // add $3 ; add $3 ; and $7,$3,$0
        rtype(3, 1, 2); tick();
        rtype(3, 4, 5); tick();
        rtype(7, 3, 0); tick();
        idle();
        pin("double", 2, 0, 0, 0);
        drain();

        // lw $8,0($1) ; add $9,$8,$2
        drive(1, 1, 8, 8, 1, 1, 0, 0); tick();
        rtype(9, 8, 2);
        pin("lu_stall", 0, 0, 1, 0);
        tick();
        rtype(9, 8, 2);
        pin("lu_bubble", 0, 0, 0, 1);
        tick();
        idle();
        pin("lu_fwd", 1, 0, 0, 0);
        drain();

        // add $0,$1,$2 ; add $5,$0,$0
        rtype(0, 1, 2); tick();
        rtype(5, 0, 0); tick();
        idle();
        pin("r0", 0, 0, 0, 0);
        drain();

        // add $3 ; addi $5,$3,4 with rt field 3, use_rt=0
        rtype(3, 1, 2); tick();
        drive(1, 3, 3, 5, 1, 0, 0, 0); tick();
        idle();
        pin("use_rt", 2, 0, 0, 0);
        drain();

        // lw $8 ; dependent add flushed in ID
        drive(1, 1, 8, 8, 1, 1, 0, 0); tick();
        drive(1, 8, 2, 9, 1, 0, 1, 1);
        pin("flush_stall", 0, 0, 0, 0);
        tick();
        idle();
        pin("flush_bub", 0, 0, 0, 1);
        tick();
        pin("flush_after", 0, 0, 0, 1);
        drain();

        // Reset mid-operation discards producers
        rtype(3, 1, 2); tick();
        rtype(4, 1, 2); tick();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        idle();
        pin("midrst", 0, 0, 0, 1);
        tick();
        rtype(6, 3, 4); tick();
        idle();
        pin("midrst_use", 0, 0, 0, 0);
        drain();

        // Random traffic over a small register range, checked by the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                  1'($urandom_range(0, 9) == 0));
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
